fifo_read_sequencer: RTL and testbench
======================================

# fifo_read_sequencer

Command-driven read sequencer for the SPI-side data FIFO. It sits between the SPI register-write path and the FIFO read port. It decodes 32-bit command writes into single reads, counted bursts and FIFO resets, and emits one-cycle `fifo_rd` strobes spaced for FIFO output settling. It never reads an empty FIFO, and it keeps sticky full and timeout alarms plus a word counter for host readback.

## Interface
- `GAP_CYCLES`, default 2: idle cycles after each `fifo_rd` pulse; legal range 1..15.
- `RST_CYCLES`, default 4: width of the `fifo_rst` pulse in clk cycles; legal range 1..15.
- `TIMEOUT`, default 255: number of WAIT cycles before a watchdog abort; 8 bits; used only when the watchdog is enabled.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: one-cycle command write strobe.
- `wr_data` in 32: command word, sampled when `wr_en`=1.
- `fifo_empty` in 1: FIFO empty flag, synchronous to clk.
- `fifo_full` in 1: FIFO full flag, synchronous to clk.
- `fifo_rd` out 1: one-cycle read strobe to the FIFO.
- `fifo_rst` out 1: FIFO reset, held high for `RST_CYCLES` cycles.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: one-cycle pulse on completion or abort of a read sequence.
- `words_read` out 16: saturating count of issued `fifo_rd` pulses.
- `full_alarm` out 1: sticky; set when `fifo_full` is sampled high.
- `timeout_alarm` out 1: sticky watchdog abort flag.
- `cmd_err` out 1: sticky flag for a read command rejected while busy.

## Operation
- Command bits:
  - bit0: single read.
  - bit1: burst read, with length in bits[15:8]; a length of 0 means 256.
  - bit16: FIFO reset.
  - bit17: clear alarms.
  - All other bits are ignored.
- Command priority:
  - bit16 has the highest priority: it aborts any sequence from any state, enters RESET, and clears `words_read`, the remaining count and all sticky flags. Bits 0, 1 and 17 of the same word are ignored.
  - bit1 and bit0 set together: the burst wins; bit0 is ignored.
  - bit0 alone: a burst of length 1.
  - A read command (bit0 or bit1) is accepted only in IDLE. If `busy` is high, it is dropped and `cmd_err` is set; any bit17 in the same word is still applied.
- bit17 clears `full_alarm`, `timeout_alarm` and `cmd_err`. If a set condition occurs in the same cycle as the clear, the set wins.
- FSM states: IDLE, RESET, WAIT, PULSE, GAP.
  - IDLE: on an accepted read command, load the 9-bit remaining count and go to WAIT.
  - WAIT: if `fifo_empty`=0, go to PULSE; otherwise stay. The watchdog, when enabled, applies here.
  - PULSE: `fifo_rd`=1 for exactly one cycle; decrement the remaining count; increment `words_read`, saturating at 0xFFFF. Always go to GAP.
  - GAP: count `GAP_CYCLES` cycles. Then go to IDLE with `done`=1 if the remaining count is 0; otherwise go to WAIT.
  - RESET: `fifo_rst`=1 for `RST_CYCLES` cycles, then go to IDLE. `done` is not asserted.
- `fifo_rd` is never asserted in the same cycle as `fifo_rst`.
- `full_alarm` is set on any clk edge where `fifo_full`=1 (except during `rst`), regardless of state.
- Reset values: state IDLE; all outputs 0; counters 0.
- Asserting `rst` mid-operation abandons the sequence immediately with no `done` pulse.

## Timing
- A `wr_en` at edge N with an accepted read command puts the FSM in WAIT after edge N+1.
- If `fifo_empty`=0 in that cycle, `fifo_rd` is high during the cycle after edge N+2.
- Back-to-back pulse period with the FIFO non-empty is 2+`GAP_CYCLES` cycles (WAIT→PULSE→GAP×`GAP_CYCLES`→WAIT).
- `done` is asserted in the cycle the FSM re-enters IDLE. `busy` falls in the same cycle.
- A bit16 command at edge N puts `fifo_rst` high from the cycle after edge N+1 for exactly `RST_CYCLES` cycles.
- `busy` is combinational from the state register; all other outputs are registered.

## Configuration
- `FIFO_RD_WATCHDOG_EN` defined:
  - An 8-bit counter runs in WAIT and is cleared on entry to WAIT.
  - When it reaches `TIMEOUT`, the FSM goes to IDLE, pulses `done`, and sets `timeout_alarm`.
  - `words_read` keeps the pulses already issued.
- `FIFO_RD_WATCHDOG_EN` undefined:
  - WAIT holds indefinitely.
  - `timeout_alarm` is tied to 0 and `TIMEOUT` is unused.

## Structure
- Package `fifo_seq_pkg` holds:
  - the state enum;
  - command bit-position constants: `CMD_SINGLE`=0, `CMD_BURST`=1, `CMD_LEN_LSB`=8, `CMD_LEN_MSB`=15, `CMD_FIFO_RST`=16, `CMD_CLR_ALARM`=17;
  - the burst-length-of-0 = 256 rule, as a function.
- Sub-module `fifo_seq_watchdog` contains the WAIT timeout counter and compare. It is instantiated only under `FIFO_RD_WATCHDOG_EN`.

## Test plan
- Burst of 4 (`wr_data`=0x0000_0402), FIFO non-empty, `GAP_CYCLES`=2: 4 `fifo_rd` pulses 4 cycles apart, the first 2 cycles after `wr_en`; `done` after the last GAP; `words_read`=4.
- Single read (0x1) with `fifo_empty`=1 for 10 cycles, then 0: no `fifo_rd` while empty; exactly 1 pulse after `fifo_empty` falls; then `done`.
- FIFO reset (0x0001_0000) issued mid-burst: `fifo_rd` stops; `fifo_rst` high for 4 cycles; counters and flags 0; no `done`.
- Read command while busy: dropped, `cmd_err`=1. Then 0x0002_0000: `cmd_err`=0. A `fifo_full` pulse sets `full_alarm` even in IDLE.
- Watchdog build, `TIMEOUT`=16, burst of 2 with the FIFO empty after the first pulse: abort to IDLE; `timeout_alarm`=1; `words_read`=1; `done` pulsed once.
- Burst length 0 (0x0000_0002): exactly 256 pulses; async `rst` mid-burst returns all outputs to 0 immediately.

Source files
------------

// File: rtl/fifo_seq_pkg.sv
// Shared types and command-word layout for the FIFO read sequencer.
// Pulled in by fifo_read_sequencer and fifo_seq_watchdog.
package fifo_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_PULSE,
    S_GAP
  } state_e;

  localparam int CMD_SINGLE    = 0;
  localparam int CMD_BURST     = 1;
  localparam int CMD_LEN_LSB   = 8;
  localparam int CMD_LEN_MSB   = 15;
  localparam int CMD_FIFO_RST  = 16;
  localparam int CMD_CLR_ALARM = 17;

  // A zero length field encodes the maximum burst of 256.
  function automatic logic [8:0] burst_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/fifo_seq_watchdog.sv
// WAIT-state timeout counter for the FIFO read sequencer.
// Only built when FIFO_RD_WATCHDOG_EN is defined.
module fifo_seq_watchdog
  import fifo_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Any cycle outside WAIT re-arms the counter for the next entry.
  assign cnt_d = wait_i ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_read_sequencer.sv
// Command-driven FIFO read sequencer: single/burst reads and FIFO reset.
// Optional WAIT watchdog enabled by defining FIFO_RD_WATCHDOG_EN.
module fifo_read_sequencer
  import fifo_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_rd,
  output logic        fifo_rst,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_read,
  output logic        full_alarm,
  output logic        timeout_alarm,
  output logic        cmd_err
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [8:0]  rem_q;
  logic [15:0] words_q;
  logic        rd_q;
  logic        frst_q;
  logic        done_q;
  logic        full_q, full_d;
  logic        tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        busy_w;
  logic        cmd_rst;
  logic        cmd_clr;
  logic        cmd_rd;
  logic [8:0]  cmd_len;
  logic        wd_expired;
  logic        wd_fire;
  logic        unused_wr_data;

  assign busy_w  = (state_q != S_IDLE);
  assign cmd_rst = wr_en & wr_data[CMD_FIFO_RST];
  assign cmd_clr = wr_en & wr_data[CMD_CLR_ALARM];
  assign cmd_rd  = wr_en & ~wr_data[CMD_FIFO_RST]
                 & (wr_data[CMD_SINGLE] | wr_data[CMD_BURST]);
  assign cmd_len = wr_data[CMD_BURST]
                 ? burst_len(wr_data[CMD_LEN_MSB:CMD_LEN_LSB])
                 : 9'd1;

  assign unused_wr_data = ^{wr_data[31:18], wr_data[7:2]};

`ifdef FIFO_RD_WATCHDOG_EN
  fifo_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (state_q == S_WAIT),
    .expired_o(wd_expired)
  );
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign wd_expired     = 1'b0;
`endif

  // A non-empty FIFO takes precedence over an expiring watchdog.
  assign wd_fire = (state_q == S_WAIT) & fifo_empty & wd_expired;

  always_comb begin
    full_d = full_q;
    tmo_d  = tmo_q;
    err_d  = err_q;
    if (cmd_rst || cmd_clr) begin
      full_d = 1'b0;
      tmo_d  = 1'b0;
      err_d  = 1'b0;
    end
    if (fifo_full)               full_d = 1'b1;
    if (wd_fire && !cmd_rst)     tmo_d  = 1'b1;
    if (cmd_rd && busy_w)        err_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rem_q   <= 9'd0;
      words_q <= 16'd0;
      rd_q    <= 1'b0;
      frst_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
      rd_q   <= 1'b0;
      frst_q <= 1'b0;
      done_q <= 1'b0;
      if (cmd_rst) begin
        state_q <= S_RESET;
        cnt_q   <= 4'd0;
        rem_q   <= 9'd0;
        words_q <= 16'd0;
        frst_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cmd_rd) begin
              rem_q   <= cmd_len;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!fifo_empty) begin
              rd_q    <= 1'b1;
              state_q <= S_PULSE;
            end else if (wd_fire) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_PULSE: begin
            rem_q   <= rem_q - 9'd1;
            cnt_q   <= 4'd0;
            state_q <= S_GAP;
            if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
          end
          S_GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q <= 4'd0;
              if (rem_q == 9'd0) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_RESET: begin
            if (cnt_q == RST_LAST) begin
              cnt_q   <= 4'd0;
              state_q <= S_IDLE;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              frst_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo_rd       = rd_q;
  assign fifo_rst      = frst_q;
  assign busy          = busy_w;
  assign done          = done_q;
  assign words_read    = words_q;
  assign full_alarm    = full_q;
  assign timeout_alarm = tmo_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_fifo_read_sequencer.sv
// Directed self-checking bench for fifo_read_sequencer.
// Watchdog scenario is selected by FIFO_RD_WATCHDOG_EN.
module tb_fifo_read_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_rd;
  logic        fifo_rst;
  logic        busy;
  logic        done;
  logic [15:0] words_read;
  logic        full_alarm;
  logic        timeout_alarm;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  fifo_read_sequencer #(
    .GAP_CYCLES(2),
    .RST_CYCLES(4),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_rd      (fifo_rd),
    .fifo_rst     (fifo_rst),
    .busy         (busy),
    .done         (done),
    .words_read   (words_read),
    .full_alarm   (full_alarm),
    .timeout_alarm(timeout_alarm),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  wire [6:0] flags = {fifo_rd, fifo_rst, busy, done,
                      full_alarm, timeout_alarm, cmd_err};

  task automatic wr_cmd(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_data = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (flags !== 7'd0 || words_read !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b/%0h expected 0/0", flags, words_read);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (flags !== 7'd0 || words_read !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b/%0h expected 0/0", flags, words_read);
    end
  endtask

  task automatic test_burst4();
    logic [19:0] rd_m, dn_m;
    rd_m = '0;
    dn_m = '0;
    fifo_empty = 1'b0;
    wr_cmd(32'h0000_0402);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rd_m[c] = fifo_rd;
      dn_m[c] = done;
    end
    checks++;
    if (rd_m !== 20'h02222) begin
      errors++;
      $display("FAIL burst4_rd_timing: got %h expected 02222", rd_m);
    end
    checks++;
    if (dn_m !== 20'h10000) begin
      errors++;
      $display("FAIL burst4_done_timing: got %h expected 10000", dn_m);
    end
    checks++;
    if (words_read !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst4_words: got %0d busy %b expected 4 busy 0",
               words_read, busy);
    end
  endtask

  task automatic test_single_empty();
    int rd_n, dn_n;
    rd_n = 0;
    dn_n = 0;
    fifo_empty = 1'b1;
    wr_cmd(32'h0000_0001);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
    end
    checks++;
    if (rd_n !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_hold_empty: got rd %0d busy %b expected 0 busy 1",
               rd_n, busy);
    end
    fifo_empty = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
    end
    checks++;
    if (rd_n !== 1 || dn_n !== 1) begin
      errors++;
      $display("FAIL single_release: got rd %0d done %0d expected 1 1",
               rd_n, dn_n);
    end
    checks++;
    if (words_read !== 16'd5) begin
      errors++;
      $display("FAIL single_words: got %0d expected 5", words_read);
    end
  endtask

  task automatic test_fifo_reset_mid_burst();
    logic [7:0] rs_m, rd_m, dn_m;
    rs_m = '0;
    rd_m = '0;
    dn_m = '0;
    fifo_empty = 1'b0;
    wr_cmd(32'h0000_0A02);
    @(negedge clk);
    @(negedge clk);
    fifo_full = 1'b1;
    wr_cmd(32'h0000_0001);
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || full_alarm !== 1'b1 || words_read !== 16'd6) begin
      errors++;
      $display("FAIL busy_drop: got err %b full %b words %0d expected 1 1 6",
               cmd_err, full_alarm, words_read);
    end
    wr_cmd(32'h0001_0003);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rs_m[c] = fifo_rst;
      rd_m[c] = fifo_rd;
      dn_m[c] = done;
      if (c == 0) begin
        checks++;
        if (words_read !== 16'd0 || cmd_err !== 1'b0 || full_alarm !== 1'b0) begin
          errors++;
          $display("FAIL rst_clears: got words %0d err %b full %b expected 0 0 0",
                   words_read, cmd_err, full_alarm);
        end
      end
    end
    checks++;
    if (rs_m !== 8'h0F) begin
      errors++;
      $display("FAIL fifo_rst_width: got %b expected 00001111", rs_m);
    end
    checks++;
    if (rd_m !== 8'h00 || dn_m !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rd_done: got rd %b done %b busy %b expected 0 0 0",
               rd_m, dn_m, busy);
    end
  endtask

  task automatic test_cmd_err_and_alarms();
    int rd_n, dn_n;
    rd_n = 0;
    dn_n = 0;
    fifo_empty = 1'b1;
    wr_cmd(32'h0000_0001);
    wr_cmd(32'h0000_0002);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_err_set: got %b busy %b expected 1 1", cmd_err, busy);
    end
    wr_cmd(32'h0002_0000);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL cmd_err_clear: got %b expected 0", cmd_err);
    end
    fifo_empty = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
    end
    checks++;
    if (rd_n !== 1 || dn_n !== 1 || words_read !== 16'd1) begin
      errors++;
      $display("FAIL dropped_no_extra: got rd %0d done %0d words %0d expected 1 1 1",
               rd_n, dn_n, words_read);
    end
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (full_alarm !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_in_idle: got %b busy %b expected 1 0", full_alarm, busy);
    end
    fifo_full = 1'b1;
    wr_cmd(32'h0002_0000);
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (full_alarm !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got %b expected 1", full_alarm);
    end
    wr_cmd(32'h0002_0000);
    @(negedge clk);
    checks++;
    if (full_alarm !== 1'b0) begin
      errors++;
      $display("FAIL full_clear: got %b expected 0", full_alarm);
    end
  endtask

  task automatic test_wait_timeout();
    int rd_n, dn_n;
    rd_n = 0;
    dn_n = 0;
    do_reset();
    fifo_empty = 1'b0;
    wr_cmd(32'h0000_0202);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
      if (c == 1) fifo_empty = 1'b1;
    end
`ifdef FIFO_RD_WATCHDOG_EN
    checks++;
    if (rd_n !== 1 || dn_n !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_abort: got rd %0d done %0d busy %b expected 1 1 0",
               rd_n, dn_n, busy);
    end
    checks++;
    if (timeout_alarm !== 1'b1 || words_read !== 16'd1) begin
      errors++;
      $display("FAIL wd_flags: got tmo %b words %0d expected 1 1",
               timeout_alarm, words_read);
    end
    fifo_empty = 1'b0;
`else
    checks++;
    if (rd_n !== 1 || dn_n !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: got rd %0d done %0d busy %b expected 1 0 1",
               rd_n, dn_n, busy);
    end
    checks++;
    if (timeout_alarm !== 1'b0 || words_read !== 16'd1) begin
      errors++;
      $display("FAIL hold_flags: got tmo %b words %0d expected 0 1",
               timeout_alarm, words_read);
    end
    fifo_empty = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
    end
    checks++;
    if (rd_n !== 2 || dn_n !== 1 || words_read !== 16'd2) begin
      errors++;
      $display("FAIL hold_release: got rd %0d done %0d words %0d expected 2 1 2",
               rd_n, dn_n, words_read);
    end
`endif
  endtask

  task automatic test_burst256_and_async_rst();
    int rd_n, dn_n;
    rd_n = 0;
    dn_n = 0;
    do_reset();
    fifo_empty = 1'b0;
    wr_cmd(32'h0000_0002);
    for (int c = 0; c < 1040; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
    end
    checks++;
    if (rd_n !== 256 || dn_n !== 1) begin
      errors++;
      $display("FAIL burst256_count: got rd %0d done %0d expected 256 1",
               rd_n, dn_n);
    end
    checks++;
    if (words_read !== 16'd256 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst256_words: got %0d busy %b expected 256 0",
               words_read, busy);
    end
    wr_cmd(32'h0000_0002);
    repeat (10) @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_pulse: got rd %b busy %b expected 1 1", fifo_rd, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (flags !== 7'd0 || words_read !== 16'd0) begin
      errors++;
      $display("FAIL async_rst: got %b/%0h expected 0/0", flags, words_read);
    end
    #1;
    rst = 1'b0;
    rd_n = 0;
    dn_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd);
      dn_n += int'(done);
    end
    checks++;
    if (rd_n !== 0 || dn_n !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_quiet: got rd %0d done %0d busy %b expected 0 0 0",
               rd_n, dn_n, busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 32'd0;
    fifo_empty = 1'b1;
    fifo_full  = 1'b0;
    test_reset();
    test_burst4();
    test_single_empty();
    test_fifo_reset_mid_burst();
    test_cmd_err_and_alarms();
    test_wait_timeout();
    test_burst256_and_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
